// File: rtl/expr_vec_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// expr_seq_pkg
// Shared types and constants for the expression-datapath self-test sequencer:
// FSM state encoding, LFSR width and feedback taps, MISR polynomial and
// initial value, and the slice width used to fold a result into the MISR.
// ----------------------------------------------------------------------------
package expr_seq_pkg;

   localparam int          LFSR_W    = 64;
   // Fibonacci taps 64,63,61,60 -> register bits 63,62,60,59
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;
   localparam int          FOLD_W    = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_DRIVE   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   // One LFSR step: shift left, XOR of the tapped bits enters bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/expr_vec_sequencer_if.sv
// ----------------------------------------------------------------------------
// expr_vec_sequencer_if
// Bundles the sequencer's run handshake and datapath buses.
//   start/seed/num_vec : run request and its parameters (harness -> sequencer)
//   opnd / res         : operand bus to and result bus from the datapath
//   busy/done/sig/vec_cnt : run status and signature (sequencer -> harness)
// With EXPR_SEQ_GOLDEN_EN defined, also carries exp_sig (expected signature,
// sampled with start) and pass (signature compare result).
// Modports: master = harness/datapath side, slave = sequencer.
// ----------------------------------------------------------------------------
interface expr_vec_sequencer_if #(
   parameter int OPW    = 60,
   parameter int RESW   = 90,
   parameter int NVEC_W = 16
);
   logic              start;
   logic [63:0]       seed;
   logic [NVEC_W-1:0] num_vec;
   logic [OPW-1:0]    opnd;
   logic [RESW-1:0]   res;
   logic              busy;
   logic              done;
   logic [31:0]       sig;
   logic [NVEC_W-1:0] vec_cnt;
`ifdef EXPR_SEQ_GOLDEN_EN
   logic [31:0]       exp_sig;
   logic              pass;

   modport master (output start, seed, num_vec, res, exp_sig,
                   input  opnd, busy, done, sig, vec_cnt, pass);
   modport slave  (input  start, seed, num_vec, res, exp_sig,
                   output opnd, busy, done, sig, vec_cnt, pass);
`else
   modport master (output start, seed, num_vec, res,
                   input  opnd, busy, done, sig, vec_cnt);
   modport slave  (input  start, seed, num_vec, res,
                   output opnd, busy, done, sig, vec_cnt);
`endif
endinterface

// File: rtl/expr_vec_sequencer_misr.sv
// ----------------------------------------------------------------------------
// expr_misr32
// Combinational next-signature function of the 32-bit MISR.
//   sig_in  : current signature
//   res_in  : datapath result, zero-padded to a multiple of 32 bits; the
//             32-bit slices are XOR-folded together
//   sig_out : (sig_in << 1) ^ (sig_in[31] ? poly : 0) ^ fold
// ----------------------------------------------------------------------------
module expr_misr32
   import expr_seq_pkg::*;
#(
   parameter int RESW = 90
) (
   input  logic [31:0]     sig_in,
   input  logic [RESW-1:0] res_in,
   output logic [31:0]     sig_out
);

   localparam int NSLICE = (RESW + FOLD_W - 1) / FOLD_W;

   logic [NSLICE*FOLD_W-1:0] pad_s;
   logic [FOLD_W-1:0]        fold_s;

   // Zero-pad the result, fold its slices, and advance the signature.
   always_comb begin
      pad_s             = '0;
      pad_s[RESW-1:0]   = res_in;
      fold_s            = '0;
      for (int i = 0; i < NSLICE; i++) begin
         fold_s = fold_s ^ pad_s[i*FOLD_W +: FOLD_W];
      end
      sig_out = {sig_in[30:0], 1'b0} ^ (sig_in[31] ? MISR_POLY : 32'h0000_0000) ^ fold_s;
   end

endmodule

// File: rtl/expr_vec_sequencer.sv
// ----------------------------------------------------------------------------
// expr_vec_sequencer
// Self-test sequencer for a combinational expression datapath. On start it
// seeds a 64-bit LFSR, then for each of num_vec vectors drives lfsr[OPW-1:0]
// onto opnd, waits SETTLE cycles, folds res into a 32-bit MISR and steps the
// LFSR. A one-cycle done pulse closes the run.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : expr_vec_sequencer_if.slave (start/seed/num_vec/res in,
//           opnd/busy/done/sig/vec_cnt out)
// Optional: EXPR_SEQ_GOLDEN_EN adds exp_sig (sampled with start) and pass
// (final sig == exp_sig, updated in DONE, cleared by start).
// ----------------------------------------------------------------------------
module expr_vec_sequencer
   import expr_seq_pkg::*;
#(
   parameter int OPW    = 60,
   parameter int RESW   = 90,
   parameter int NVEC_W = 16,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   expr_vec_sequencer_if.slave  bus
);

   localparam int             SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0] SETTLE_LOAD = SCW'((SETTLE > 0) ? (SETTLE - 1) : 0);

   state_e              state_r;
   state_e              state_s;
   logic [LFSR_W-1:0]   lfsr_r;
   logic [NVEC_W-1:0]   num_vec_r;
   logic [NVEC_W-1:0]   vec_cnt_r;
   logic [NVEC_W-1:0]   vec_cnt_inc_s;
   logic [SCW-1:0]      settle_cnt_r;
   logic [31:0]         sig_r;
   logic [31:0]         misr_next_s;
   logic [OPW-1:0]      opnd_r;
   logic                busy_r;
   logic                busy_s;
   logic                done_r;
   logic                done_s;

   assign vec_cnt_inc_s = vec_cnt_r + NVEC_W'(1);

   expr_misr32 #(.RESW(RESW)) u_misr (
      .sig_in  (sig_r),
      .res_in  (bus.res),
      .sig_out (misr_next_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_s = ST_LOAD;
            else           state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (num_vec_r == NVEC_W'(0)) state_s = ST_DONE;
            else                         state_s = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (SETTLE > 0) state_s = ST_SETTLE;
            else            state_s = ST_CAPTURE;
         end
         ST_SETTLE: begin
            if (settle_cnt_r == SCW'(0)) state_s = ST_CAPTURE;
            else                         state_s = ST_SETTLE;
         end
         ST_CAPTURE: begin
            // Compare in NVEC_W bits so a full-scale count still terminates.
            if (vec_cnt_inc_s == num_vec_r) state_s = ST_DONE;
            else                            state_s = ST_DRIVE;
         end
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from the next state so they can be registered.
   always_comb begin
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_DONE);
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
      end
   end

   // Run datapath: LFSR, operand register, settle counter, MISR, vector count.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r       <= 64'h1;
         num_vec_r    <= '0;
         vec_cnt_r    <= '0;
         settle_cnt_r <= '0;
         sig_r        <= MISR_INIT;
         opnd_r       <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  num_vec_r <= bus.num_vec;
                  // An all-zero seed would lock the LFSR.
                  lfsr_r    <= (bus.seed == 64'h0) ? 64'h1 : bus.seed;
                  sig_r     <= MISR_INIT;
                  vec_cnt_r <= '0;
               end
            end
            ST_DRIVE: begin
               opnd_r       <= lfsr_r[OPW-1:0];
               settle_cnt_r <= SETTLE_LOAD;
            end
            ST_SETTLE: begin
               if (settle_cnt_r != SCW'(0)) settle_cnt_r <= settle_cnt_r - SCW'(1);
            end
            ST_CAPTURE: begin
               sig_r     <= misr_next_s;
               vec_cnt_r <= vec_cnt_inc_s;
               lfsr_r    <= lfsr_next(lfsr_r);
            end
            default: begin
            end
         endcase
      end
   end

`ifdef EXPR_SEQ_GOLDEN_EN
   logic [31:0] exp_sig_r;
   logic        pass_r;

   // Golden-signature compare: latch expectation on start, judge in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_sig_r <= 32'h0000_0000;
         pass_r    <= 1'b0;
      end else if ((state_r == ST_IDLE) && bus.start) begin
         exp_sig_r <= bus.exp_sig;
         pass_r    <= 1'b0;
      end else if (state_r == ST_DONE) begin
         pass_r    <= (sig_r == exp_sig_r);
      end
   end

   assign bus.pass = pass_r;
`endif

   assign bus.opnd    = opnd_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.sig     = sig_r;
   assign bus.vec_cnt = vec_cnt_r;

endmodule

// File: doc/expr_vec_sequencer.md
Name: expr_vec_sequencer

Overview:
- Self-test sequencer for one generated combinational expression datapath: 60-bit operand bus in, 90-bit result bus out.
- Generates pseudo-random operand vectors from a 64-bit LFSR and drives them onto the datapath.
- Waits a programmable settle time, then folds each 90-bit result into a 32-bit MISR signature.
- Runs a start/busy/done handshake so a regression harness can run N vectors and compare signatures across builds.

Parameters:
- OPW, 60: operand bus width, {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, MSB first (a0 = opnd[59:56]).
- RESW, 90: result bus width.
- NVEC_W, 16: vector-count width.
- SETTLE, 1: extra cycles between driving operands and capturing the result (0 allowed).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- seed  in  64  LFSR seed, sampled with start.
- num_vec  in  NVEC_W  vector count, sampled with start.
- opnd  out  OPW  operand bus to datapath.
- res  in  RESW  datapath result.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- sig  out  32  MISR signature.
- vec_cnt  out  NVEC_W  vectors captured in current/last run.

Behaviour:
- Reset values: opnd=0, busy=0, done=0, sig=32'hFFFFFFFF, vec_cnt=0, lfsr=64'h1, state=IDLE.
- States: IDLE, LOAD, DRIVE, SETTLE, CAPTURE, DONE.
- IDLE, start=1: go to LOAD. Latch num_vec. lfsr<=seed, or 64'h1 if seed==0. sig<=FFFFFFFF. vec_cnt<=0.
- busy=1 in every state except IDLE.
- start while busy: ignored, no queueing.
- LOAD: if latched num_vec==0, go to DONE; sig stays FFFFFFFF. Otherwise go to DRIVE.
- DRIVE (1 cycle): opnd<=lfsr[59:0]. Go to SETTLE if SETTLE>0, else CAPTURE.
- SETTLE: stays SETTLE cycles (down-counter), then goes to CAPTURE.
- CAPTURE (1 cycle), all on one edge:
  - fold = res zero-padded to 96 bits, XOR of its three 32-bit slices.
  - sig<={sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
  - vec_cnt<=vec_cnt+1.
  - LFSR steps once: Fibonacci, taps 64,63,61,60; shift left, feedback into bit 0.
  - If vec_cnt+1==num_vec, go to DONE; else go to DRIVE.
- DONE (1 cycle): done=1, busy=1, then IDLE. sig, vec_cnt and opnd hold until the next start.
- Run length for N>0: 2 + N*(2+SETTLE) cycles from the start-sampling edge to the first IDLE cycle.
- num_vec = 2^NVEC_W-1 runs to completion; vec_cnt never wraps within a run.
- reset mid-run: aborts immediately to reset values; no done pulse.
- opnd is registered, so the datapath sees stable operands from DRIVE+1 through CAPTURE.

Optional Feature:
- Macro: EXPR_SEQ_GOLDEN_EN.
- When defined, adds:
  - input exp_sig[31:0], sampled with start.
  - output pass, reset 0, updated in DONE to (final sig == exp_sig), held until the next start; start clears it to 0.
- When undefined: ports absent, no compare logic.

Decomposition:
- Package expr_seq_pkg holds:
  - state enum;
  - LFSR_W=64, LFSR tap constant;
  - MISR polynomial 32'h04C11DB7, MISR init 32'hFFFFFFFF;
  - FOLD_W=32.
- One sub-module: expr_misr32, combinational next-signature function (sig, res) -> next sig. The verifier's reference model reuses it.

Test Plan:
- res tied to 0, num_vec=1, SETTLE=1, seed=1 → done 5 cycles after start; sig=32'hFB3EE249; vec_cnt=1.
- num_vec=0, start → done 2 cycles after start; sig=FFFFFFFF; opnd stays 0.
- seed=0 versus seed=1, same num_vec=4, res=0 → identical opnd sequences and identical sig.
- start pulsed every cycle during an 8-vector run → exactly one done; vec_cnt=8; no restart.
- reset asserted in the 3rd SETTLE cycle of an 8-vector run → next cycle busy=0, done=0, sig=FFFFFFFF, vec_cnt=0, opnd=0; a subsequent clean run matches the reference model.
- res={opnd,30'h0} loopback, num_vec=100, seed=64'hDEADBEEF → final sig matches expr_misr32-based model.
  - With EXPR_SEQ_GOLDEN_EN: pass=1 for the matching exp_sig, pass=0 for exp_sig^1.
